// File: rtl/vga_layer_scheduler.sv
// rtl/vga_layer_scheduler.sv - fixed-priority pixel layer arbiter with blank-synchronised enable config
//
// Ports:
//   pixel_clk     pixel clock, all state on rising edge
//   reset         asynchronous active-low reset
//   video_active  visible-area qualifier from the timing generator
//   vblank_start  one-cycle pulse at the first line of vertical blanking
//   layer_req     per-layer opaque-pixel request
//   layer_color   per-layer colour, layer i at [i*COLOR_W +: COLOR_W]
//   cfg_valid     new enable mask offered
//   cfg_enable    offered enable mask
//   cfg_ready     shadow register free
//   color_data    registered arbitrated pixel
//   layer_grant   registered one-hot winner, aligned with color_data
//   frame_count   completed frames, mod 256
//   collision     sticky overlap flag (built only with VGA_LAYER_COLLISION_EN)
//
// Optional feature macro: VGA_LAYER_COLLISION_EN
module vga_layer_scheduler #(
    parameter int                 NUM_LAYERS = 4,
    parameter int                 COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR   = '0
) (
    input  logic                          pixel_clk,
    input  logic                          reset,
    input  logic                          video_active,
    input  logic                          vblank_start,
    input  logic [NUM_LAYERS-1:0]         layer_req,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic                          cfg_valid,
    input  logic [NUM_LAYERS-1:0]         cfg_enable,
    output logic                          cfg_ready,
    output logic [COLOR_W-1:0]            color_data,
    output logic [NUM_LAYERS-1:0]         layer_grant,
    output logic [7:0]                    frame_count,
    output logic                          collision
);

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        UPDATE = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    pending;
    logic [NUM_LAYERS-1:0]   shadow_mask;
    logic [NUM_LAYERS-1:0]   en_mask;
    logic [NUM_LAYERS-1:0]   masked;
    logic [COLOR_W-1:0]      win_color;
    logic [NUM_LAYERS-1:0]   win_grant;
    logic                    cfg_xfer;

    assign cfg_ready = !pending;
    assign cfg_xfer  = cfg_valid && !pending;

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state <= BLANK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BLANK: begin
                if (pending) begin
                    state_next = UPDATE;
                end else if (video_active) begin
                    state_next = ACTIVE;
                end
            end
            UPDATE: begin
                state_next = video_active ? ACTIVE : BLANK;
            end
            ACTIVE: begin
                // Horizontal blanking drops video_active but stays in-frame.
                if (vblank_start) begin
                    state_next = BLANK;
                end
            end
            default: state_next = BLANK;
        endcase
    end

    // The active mask only changes at the end of UPDATE, so the pixel
    // sampled during UPDATE still sees the old mask.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            pending     <= 1'b0;
            shadow_mask <= '0;
            en_mask     <= '1;
        end else if (state == UPDATE) begin
            en_mask <= shadow_mask;
            pending <= 1'b0;
        end else if (cfg_xfer) begin
            shadow_mask <= cfg_enable;
            pending     <= 1'b1;
        end
    end

    // Ascending scan: a later (higher-index) hit overrides earlier ones.
    always_comb begin
        masked    = layer_req & en_mask;
        win_color = BG_COLOR;
        win_grant = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (masked[i]) begin
                win_color    = layer_color[i*COLOR_W +: COLOR_W];
                win_grant    = '0;
                win_grant[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            color_data  <= '0;
            layer_grant <= '0;
            frame_count <= '0;
        end else begin
            if (video_active) begin
                color_data  <= win_color;
                layer_grant <= win_grant;
            end else begin
                color_data  <= '0;
                layer_grant <= '0;
            end
            if (vblank_start) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

`ifdef VGA_LAYER_COLLISION_EN
    logic overlap;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign overlap = video_active && (|(masked & (masked - NUM_LAYERS'(1))));

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            collision <= 1'b0;
        end else if (overlap) begin
            collision <= 1'b1;
        end else if (vblank_start) begin
            collision <= 1'b0;
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_vga_layer_scheduler.sv
// tb/tb_vga_layer_scheduler.sv - self-checking bench for vga_layer_scheduler
module tb_vga_layer_scheduler;

    localparam int NL = 4;
    localparam int CW = 12;
    localparam logic [CW-1:0] BG = 12'h000;

    localparam int P_BLANK  = 0;
    localparam int P_UPDATE = 1;
    localparam int P_ACTIVE = 2;

    logic              pixel_clk = 1'b0;
    logic              reset = 1'b0;
    logic              video_active = 1'b0;
    logic              vblank_start = 1'b0;
    logic [NL-1:0]     layer_req = '0;
    logic [NL*CW-1:0]  layer_color = '0;
    logic              cfg_valid = 1'b0;
    logic [NL-1:0]     cfg_enable = '0;
    logic              cfg_ready;
    logic [CW-1:0]     color_data;
    logic [NL-1:0]     layer_grant;
    logic [7:0]        frame_count;
    logic              collision;

    vga_layer_scheduler #(.NUM_LAYERS(NL), .COLOR_W(CW), .BG_COLOR(BG)) dut (
        .pixel_clk    (pixel_clk),
        .reset        (reset),
        .video_active (video_active),
        .vblank_start (vblank_start),
        .layer_req    (layer_req),
        .layer_color  (layer_color),
        .cfg_valid    (cfg_valid),
        .cfg_enable   (cfg_enable),
        .cfg_ready    (cfg_ready),
        .color_data   (color_data),
        .layer_grant  (layer_grant),
        .frame_count  (frame_count),
        .collision    (collision)
    );

    always #20 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] col [NL];

    logic [NL-1:0] m_mask;
    logic [NL-1:0] m_shadow;
    bit            m_pending;
    int            m_ph;
    logic [CW-1:0] e_color;
    logic [NL-1:0] e_grant;
    logic [7:0]    e_fc;
    logic          e_coll;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mask    = '1;
        m_shadow  = '0;
        m_pending = 0;
        m_ph      = P_BLANK;
        e_color   = '0;
        e_grant   = '0;
        e_fc      = '0;
        e_coll    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".color"}, 32'(color_data), 32'(e_color));
        check({tag, ".grant"}, 32'(layer_grant), 32'(e_grant));
        check({tag, ".ready"}, 32'(cfg_ready), 32'(!m_pending));
        check({tag, ".frame"}, 32'(frame_count), 32'(e_fc));
        check({tag, ".coll"}, 32'(collision), 32'(e_coll));
    endtask

    // One pixel clock: drive, clock, advance the reference, compare.
    task automatic step(input string tag, input bit va, input bit vb, input bit cv,
                        input logic [NL-1:0] ce, input logic [NL-1:0] req);
        logic [NL-1:0] hit;
        bit            old_pend;
        bit            found;
        video_active = va;
        vblank_start = vb;
        cfg_valid    = cv;
        cfg_enable   = ce;
        layer_req    = req;
        for (int i = 0; i < NL; i++) layer_color[i*CW +: CW] = col[i];
        @(posedge pixel_clk);
        hit      = req & m_mask;
        old_pend = m_pending;
        e_grant  = '0;
        e_color  = va ? BG : '0;
        found    = 0;
        if (va) begin
            for (int i = NL - 1; i >= 0; i--) begin
                if (!found && hit[i]) begin
                    found   = 1;
                    e_color = col[i];
                    e_grant = NL'(1 << i);
                end
            end
        end
`ifdef VGA_LAYER_COLLISION_EN
        if (va && $countones(hit) >= 2) e_coll = 1'b1;
        else if (vb) e_coll = 1'b0;
`endif
        if (vb) e_fc = e_fc + 8'd1;
        if (m_ph == P_UPDATE) begin
            m_mask    = m_shadow;
            m_pending = 0;
        end else if (cv && !m_pending) begin
            m_shadow  = ce;
            m_pending = 1;
        end
        case (m_ph)
            P_BLANK:  m_ph = old_pend ? P_UPDATE : (va ? P_ACTIVE : P_BLANK);
            P_UPDATE: m_ph = va ? P_ACTIVE : P_BLANK;
            default:  m_ph = vb ? P_BLANK : P_ACTIVE;
        endcase
        #1;
        check_all(tag);
    endtask

    initial begin
        col[0] = 12'hF00;
        col[1] = 12'h00F;
        col[2] = 12'h0F0;
        col[3] = 12'hFFF;
        model_reset();

        // Reset state
        #5;
        check_all("reset");
        @(negedge pixel_clk);
        reset = 1'b1;

        // Reset mid-line
        step("line0", 1, 0, 0, '0, 4'b0001);
        step("line1", 1, 0, 0, '0, 4'b0001);
        reset = 1'b0;
        #1;
        check("rst_async.color", 32'(color_data), 32'h0);
        check("rst_async.grant", 32'(layer_grant), 32'h0);
        check("rst_async.ready", 32'(cfg_ready), 32'h1);
        model_reset();
        #1;
        reset = 1'b1;
        step("rel", 1, 0, 0, '0, 4'b0001);
        check("rel.l0", 32'(color_data), 32'hF00);

        // Priority
        step("prio", 1, 0, 0, '0, 4'b0101);
        check("prio.color", 32'(color_data), 32'h0F0);
        check("prio.grant", 32'(layer_grant), 32'b0100);
        step("bg", 1, 0, 0, '0, 4'b0000);
        check("bg.color", 32'(color_data), 32'(BG));

        // Deferred config
        step("dcfg", 1, 0, 1, 4'b1011, 4'b0100);
        check("dcfg.ready", 32'(cfg_ready), 32'h0);
        step("dcfg_hold0", 1, 0, 0, '0, 4'b0100);
        step("dcfg_hold1", 0, 0, 0, '0, 4'b0100);
        step("dcfg_hold2", 1, 0, 0, '0, 4'b0100);
        check("dcfg.l2vis", 32'(color_data), 32'h0F0);
        step("dcfg_vb", 0, 1, 0, '0, 4'b0000);
        step("dcfg_blank", 0, 0, 0, '0, 4'b0000);
        step("dcfg_upd", 0, 0, 0, '0, 4'b0000);
        check("dcfg.ready_back", 32'(cfg_ready), 32'h1);
        step("dcfg_nf", 1, 0, 0, '0, 4'b0100);
        check("dcfg.l2off", 32'(color_data), 32'(BG));

        // Back-pressure: two masks offered back to back
        step("bp_a", 1, 0, 1, 4'b1100, 4'b0000);
        step("bp_b0", 1, 0, 1, 4'b0011, 4'b0000);
        step("bp_b1", 1, 0, 1, 4'b0011, 4'b0000);
        check("bp.held", 32'(cfg_ready), 32'h0);
        step("bp_vb", 0, 1, 1, 4'b0011, 4'b0000);
        step("bp_blank", 0, 0, 1, 4'b0011, 4'b0000);
        step("bp_upd", 0, 0, 1, 4'b0011, 4'b0000);
        step("bp_acc", 0, 0, 1, 4'b0011, 4'b0000);
        check("bp.second", 32'(cfg_ready), 32'h0);
        step("bp_blank2", 0, 0, 0, '0, 4'b0000);
        step("bp_upd2", 0, 0, 0, '0, 4'b0000);
        step("bp_use", 1, 0, 0, '0, 4'b1111);
        check("bp.mask", 32'(layer_grant), 32'b0010);

        // Collision: mask is now 4'b0011
        step("coll_set", 1, 0, 0, '0, 4'b0011);
        step("coll_hold", 1, 0, 0, '0, 4'b0000);
        step("coll_vb", 0, 1, 0, '0, 4'b0000);
        check("coll.cleared", 32'(collision), 32'h0);

        // Frame counter wrap
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        for (int n = 0; n < 257; n++) step("fc", 0, 1, 0, '0, '0);
        check("fc.257", 32'(frame_count), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NL; i++) col[i] = CW'($urandom);
            step("rnd", ($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 3) == 0,
                 NL'($urandom), NL'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
